// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO serializer.
// PISO_PARITY_EN (optional) adds a trailing even-parity bit to every frame.
package piso_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} piso_state_t;
    localparam int PISO_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/piso_hold_buf.sv
// One-entry holding buffer between the upstream handshake and the shifter.
// A write on the same edge as a read wins, so the buffer stays full with the new word.
module piso_hold_buf
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic             rd_en_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);
    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                data_q <= data_i;
                full_q <= 1'b1;
            end else if (rd_en_i) begin
                full_q <= 1'b0;
            end
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;
endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with one-entry buffer and frame marker.
// Define PISO_PARITY_EN to append an even-parity bit (PAR state) to every frame.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = PISO_DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             busy
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    piso_state_t      state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    bit_cnt_q;
    logic             sout_q, sout_valid_q, frame_start_q;
    logic             hold_full, load, accept;
    logic [WIDTH-1:0] hold_data;
`ifdef PISO_PARITY_EN
    logic             par_q;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Remaining bits after the head has been sent; zeros shift in behind.
    function automatic logic [WIDTH-1:0] rest(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign accept = din_valid && !hold_full;
`ifdef PISO_PARITY_EN
    assign load = hold_full && (state_q == IDLE || state_q == PAR);
`else
    assign load = hold_full && (state_q == IDLE ||
                                (state_q == SHIFT && bit_cnt_q == LAST));
`endif

    piso_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (accept),
        .rd_en_i (load),
        .data_i  (din),
        .data_o  (hold_data),
        .full_o  (hold_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            sout_q        <= 1'b0;
            sout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            frame_start_q <= 1'b0;
            if (load) begin
                state_q       <= SHIFT;
                shreg_q       <= rest(hold_data);
                bit_cnt_q     <= '0;
                sout_q        <= head(hold_data);
                sout_valid_q  <= 1'b1;
                frame_start_q <= 1'b1;
`ifdef PISO_PARITY_EN
                par_q         <= ^hold_data;
`endif
            end else begin
                case (state_q)
                    SHIFT: begin
                        if (bit_cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
                            state_q <= PAR;
                            sout_q  <= par_q;
`else
                            state_q      <= IDLE;
                            sout_q       <= 1'b0;
                            sout_valid_q <= 1'b0;
`endif
                        end else begin
                            sout_q    <= head(shreg_q);
                            shreg_q   <= rest(shreg_q);
                            bit_cnt_q <= bit_cnt_q + CW'(1);
                        end
                    end
                    // IDLE with nothing buffered, or PAR finished with no reload
                    default: begin
                        state_q      <= IDLE;
                        sout_q       <= 1'b0;
                        sout_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign din_ready   = !hold_full;
    assign sout        = sout_q;
    assign sout_valid  = sout_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != IDLE) || hold_full;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB-first and LSB-first instances at WIDTH=4.
module tb_piso_serializer;
    import piso_pkg::*;

`ifdef PISO_PARITY_EN
    localparam int FL      = 5;
    localparam int LASTACC = 12;
`else
    localparam int FL      = 4;
    localparam int LASTACC = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] m_din, l_din;
    logic       m_valid, l_valid;
    logic       m_ready, m_sout, m_sval, m_fs, m_busy;
    logic       l_ready, l_sout, l_sval, l_fs, l_busy;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(m_din), .din_valid(m_valid), .din_ready(m_ready),
        .sout(m_sout), .sout_valid(m_sval), .frame_start(m_fs), .busy(m_busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
        .sout(l_sout), .sout_valid(l_sval), .frame_start(l_fs), .busy(l_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame bit i: data bits in send order, then even parity.
    function automatic logic fbit(input logic [3:0] w, input int i, input bit msb);
        if (i < 4) return msb ? w[3-i] : w[i];
        return ^w;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sout"},  m_sout,  1'b0);
        chk({tag, "_sval"},  m_sval,  1'b0);
        chk({tag, "_fs"},    m_fs,    1'b0);
        chk({tag, "_busy"},  m_busy,  1'b0);
        chk({tag, "_ready"}, m_ready, 1'b1);
    endtask

    initial begin
        logic [3:0] vals [24];
        logic [3:0] acc  [4];
        logic [3:0] cap;
        logic [4:0] pexp;
        int         fs;

        vals = '{4'h3, 4'h5, 4'h9, 4'hE, 4'h6, 4'hB, 4'hC, 4'h1, 4'h7, 4'hA, 4'hD, 4'h2,
                 4'h8, 4'h4, 4'hF, 4'h0, 4'h3, 4'h5, 4'h9, 4'hE, 4'h6, 4'hB, 4'hC, 4'h1};
`ifdef PISO_PARITY_EN
        acc = '{4'h3, 4'h9, 4'h1, 4'h8};
`else
        acc = '{4'h3, 4'h9, 4'hC, 4'hD};
`endif
        rst = 1'b0; m_din = '0; l_din = '0; m_valid = 1'b0; l_valid = 1'b0;
        tick(); tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Single word 1010, MSB first
        m_din = 4'b1010; m_valid = 1'b1;
        tick();
        chk("single_ready_e0", m_ready, 1'b0);
        chk("single_busy_e0",  m_busy,  1'b1);
        chk("single_sval_e0",  m_sval,  1'b0);
        m_valid = 1'b0;
        cap = '0;
        for (int i = 0; i < FL; i++) begin
            tick();
            chk($sformatf("single_bit%0d", i), m_sout, fbit(4'b1010, i, 1'b1));
            chk($sformatf("single_sval%0d", i), m_sval, 1'b1);
            chk($sformatf("single_fs%0d", i), m_fs, (i == 0));
            if (i < 4) cap = {cap[2:0], m_sout};
        end
        chk("single_capture", cap, 4'b1010);
        tick();
        chk("single_idle_sval", m_sval, 1'b0);
        chk("single_idle_busy", m_busy, 1'b0);
        chk("single_idle_ready", m_ready, 1'b1);

        // LSB first 1010 -> 0,1,0,1
        l_din = 4'b1010; l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            tick();
            chk($sformatf("lsb_bit%0d", i), l_sout, fbit(4'b1010, i, 1'b0));
            chk($sformatf("lsb_sval%0d", i), l_sval, 1'b1);
        end
        tick();
        chk("lsb_idle_sval", l_sval, 1'b0);

        // Back-to-back 1100 then 0011
        m_din = 4'b1100; m_valid = 1'b1;
        tick();
        chk("b2b_ready_e0", m_ready, 1'b0);
        m_din = 4'b0011;
        fs = 0;
        for (int j = 0; j < 2*FL; j++) begin
            tick();
            if (j == 1) begin
                chk("b2b_ready_full", m_ready, 1'b0);
                m_valid = 1'b0;
            end
            chk($sformatf("b2b_bit%0d", j), m_sout,
                (j < FL) ? fbit(4'b1100, j, 1'b1) : fbit(4'b0011, j - FL, 1'b1));
            chk($sformatf("b2b_sval%0d", j), m_sval, 1'b1);
            fs += int'(m_fs);
        end
        chk("b2b_fs_count", fs, 2);
        tick();
        chk("b2b_idle_sval", m_sval, 1'b0);

        // Backpressure: din changes every cycle, only accepted words appear
        for (int k = 0; k <= 4*FL; k++) begin
            m_din   = vals[k];
            m_valid = (k <= LASTACC);
            tick();
            if (k >= 1) begin
                chk($sformatf("bp_bit%0d", k - 1), m_sout,
                    fbit(acc[(k-1)/FL], (k-1) % FL, 1'b1));
                chk($sformatf("bp_sval%0d", k - 1), m_sval, 1'b1);
            end
        end
        m_valid = 1'b0;
        tick();
        chk("bp_idle_sval", m_sval, 1'b0);
        chk("bp_idle_busy", m_busy, 1'b0);

`ifdef PISO_PARITY_EN
        // Parity frames: 1011 -> 1,0,1,1,1 and 1001 -> 1,0,0,1,0
        m_din = 4'b1011; m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        pexp = 5'b10111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("par1_bit%0d", i), m_sout, pexp[4-i]);
            chk($sformatf("par1_sval%0d", i), m_sval, 1'b1);
        end
        tick();
        chk("par1_idle", m_sval, 1'b0);
        m_din = 4'b1001; m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        pexp = 5'b10010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("par2_bit%0d", i), m_sout, pexp[4-i]);
        end
        tick();
        chk("par2_idle", m_sval, 1'b0);
`endif

        // Reset asserted mid-frame takes effect without a clock edge
        m_din = 4'b1111; m_valid = 1'b1;
        tick();
        m_valid = 1'b0;
        tick(); tick();
        chk("mid_sval_before", m_sval, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("midrst_discard_sval", m_sval, 1'b0);
        chk("midrst_discard_busy", m_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
